// File: rtl/matmul_out_collector_pkg.sv
// Shared definitions for the matmul output collector: state encoding and
// default element format (signed Q8.8 in 16 bits).
package matmul_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 16;
  localparam int unsigned DEFAULT_FRAC_WIDTH = 8;

  typedef enum logic [1:0] {
    COLL_IDLE    = 2'd0,
    COLL_COLLECT = 2'd1,
    COLL_DONE    = 2'd2
  } coll_state_e;

endpackage

// File: rtl/matmul_out_collector_if.sv
// Row-stream bundle between the matmul core, the collector and its consumer.
// master drives rows/ready/enable, slave is the collector.
interface matmul_out_collector_if
  import matmul_pkg::*;
#(
  parameter int WIDTH             = DEFAULT_WIDTH,
  parameter int W_OUTER_DIMENSION = 6
);

  localparam int ROW_W = WIDTH * W_OUTER_DIMENSION;

  logic             en_collector;
  logic             in_row_valid;
  logic [ROW_W-1:0] in_row_data;
  logic             in_row_last;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_data;
  logic             out_last;
  logic             out_done;
  logic             err_overflow;
  logic             err_last;

  modport master (
    output en_collector, in_row_valid, in_row_data, in_row_last, out_ready,
    input  out_valid, out_data, out_last, out_done, err_overflow, err_last
  );

  modport slave (
    input  en_collector, in_row_valid, in_row_data, in_row_last, out_ready,
    output out_valid, out_data, out_last, out_done, err_overflow, err_last
  );

endinterface

// File: rtl/matmul_out_collector_row_fifo.sv
// Row buffer: power-of-two depth circular FIFO with a registered head entry
// so the consumer sees a flop output with one cycle of write-to-read latency.
module row_fifo #(
  parameter int DATA_W = 97,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              valid_q, valid_d;
  logic              full_s, push_ok_s, pop_ok_s;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  always_comb begin
    full_s    = (count_q == CNT_W'(DEPTH));
    pop_ok_s  = pop_i & valid_q;
    push_ok_s = push_i & (~full_s | pop_ok_s);
  end

  // Pointer, occupancy and head-entry next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // The incoming row becomes the head when it lands in the slot being read next.
    if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wdata_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    valid_d = (count_d != {CNT_W{1'b0}});
  end

  // Storage array write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign head_o  = head_q;
  assign full_o  = full_s;
  assign empty_o = ~valid_q;

endmodule

// File: rtl/matmul_out_collector.sv
// Collects the I_OUTER_DIMENSION result rows of one matmul into a small FIFO
// and streams them downstream. Optional ReLU at push time: MATMUL_COLLECTOR_RELU_EN.
module matmul_out_collector
  import matmul_pkg::*;
#(
  parameter int WIDTH             = DEFAULT_WIDTH,
  parameter int FRAC_WIDTH        = DEFAULT_FRAC_WIDTH,
  parameter int W_OUTER_DIMENSION = 6,
  parameter int I_OUTER_DIMENSION = 12,
  parameter int FIFO_DEPTH        = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  matmul_out_collector_if.slave  bus
);

  localparam int ROW_W     = WIDTH * W_OUTER_DIMENSION;
  localparam int CNT_W     = $clog2(I_OUTER_DIMENSION + 1);
  localparam int INT_WIDTH = WIDTH - FRAC_WIDTH;
  // Sign bit of a Q(INT.FRAC) element, relative to the element's LSB.
  localparam int SIGN_BIT  = INT_WIDTH + FRAC_WIDTH - 1;
`ifdef MATMUL_COLLECTOR_RELU_EN
  localparam bit RELU_EN   = 1'b1;
`else
  localparam bit RELU_EN   = 1'b0;
`endif

  coll_state_e      state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic             err_ov_q, err_ov_d;
  logic             err_last_q, err_last_d;

  logic             collect_en_s, pop_s, push_s, arrive_s, overflow_s;
  logic             row_slot_s, last_exp_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [ROW_W:0]   fifo_head_s;
  logic [ROW_W-1:0] relu_row_s, push_row_s;

  // Negative elements clamp to zero when the ReLU build is selected.
  always_comb begin
    relu_row_s = bus.in_row_data;
    for (int j = 0; j < W_OUTER_DIMENSION; j++) begin
      if (bus.in_row_data[j*WIDTH + SIGN_BIT]) begin
        relu_row_s[j*WIDTH +: WIDTH] = {WIDTH{1'b0}};
      end else begin
        relu_row_s[j*WIDTH +: WIDTH] = bus.in_row_data[j*WIDTH +: WIDTH];
      end
    end
    push_row_s = RELU_EN ? relu_row_s : bus.in_row_data;
  end

  // Handshake qualification; rows past the last index are silently ignored.
  always_comb begin
    collect_en_s = bus.en_collector & (state_q == COLL_COLLECT);
    pop_s        = collect_en_s & ~fifo_empty_s & bus.out_ready;
    row_slot_s   = (in_cnt_q < CNT_W'(I_OUTER_DIMENSION));
    arrive_s     = collect_en_s & bus.in_row_valid & row_slot_s;
    push_s       = arrive_s & (~fifo_full_s | pop_s);
    overflow_s   = arrive_s & fifo_full_s & ~pop_s;
    last_exp_s   = (in_cnt_q == CNT_W'(I_OUTER_DIMENSION - 1));
  end

  // Row counter and sticky error next state.
  always_comb begin
    in_cnt_d   = in_cnt_q;
    err_ov_d   = err_ov_q | overflow_s;
    err_last_d = err_last_q | (push_s & (bus.in_row_last != last_exp_s));
    if (state_q == COLL_IDLE) begin
      in_cnt_d = {CNT_W{1'b0}};
    end else if (push_s) begin
      in_cnt_d = in_cnt_q + CNT_W'(1);
    end else begin
      in_cnt_d = in_cnt_q;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLL_IDLE: begin
        if (bus.en_collector) begin
          state_d = COLL_COLLECT;
        end else begin
          state_d = COLL_IDLE;
        end
      end
      COLL_COLLECT: begin
        if (pop_s && fifo_head_s[ROW_W]) begin
          state_d = COLL_DONE;
        end else begin
          state_d = COLL_COLLECT;
        end
      end
      COLL_DONE: begin
        if (!bus.en_collector) begin
          state_d = COLL_IDLE;
        end else begin
          state_d = COLL_DONE;
        end
      end
      default: state_d = COLL_IDLE;
    endcase
  end

  // FSM state, row counter and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLL_IDLE;
      in_cnt_q   <= '0;
      err_ov_q   <= 1'b0;
      err_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      err_ov_q   <= err_ov_d;
      err_last_q <= err_last_d;
    end
  end

  // Each entry carries a tag bit marking the final row of the matmul.
  row_fifo #(
    .DATA_W (ROW_W + 1),
    .DEPTH  (FIFO_DEPTH)
  ) u_row_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i ({last_exp_s, push_row_s}),
    .head_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // FSM outputs.
  always_comb begin
    bus.out_valid    = ~fifo_empty_s & (state_q == COLL_COLLECT);
    bus.out_data     = fifo_head_s[ROW_W-1:0];
    bus.out_last     = bus.out_valid & fifo_head_s[ROW_W];
    bus.out_done     = (state_q == COLL_DONE);
    bus.err_overflow = err_ov_q;
    bus.err_last     = err_last_q;
  end

endmodule

// File: tb/tb_matmul_out_collector.sv
// Randomised and directed bench for matmul_out_collector against a queue-based
// model of the collector's row-buffering rules.
module tb_matmul_out_collector;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int WO    = 6;
  localparam int IO    = 12;
  localparam int DEPTH = 4;
  localparam int ROW_W = WIDTH * WO;

  typedef struct packed {
    logic             last;
    logic [ROW_W-1:0] data;
  } row_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matmul_out_collector_if #(.WIDTH(WIDTH), .W_OUTER_DIMENSION(WO)) bus ();

  matmul_out_collector #(
    .WIDTH(WIDTH), .FRAC_WIDTH(FRAC), .W_OUTER_DIMENSION(WO),
    .I_OUTER_DIMENSION(IO), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  row_t mq[$];
  int   m_state;     // 0 idle, 1 collecting, 2 done
  int   m_in_cnt;
  bit   m_err_ov, m_err_last;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out;       // handshakes observed on the DUT outputs
  int   last_at;     // index of the handshake that carried out_last

  task automatic check_val(input string tag, input logic [ROW_W-1:0] obs,
                           input logic [ROW_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] fill_row(input logic [WIDTH-1:0] e);
    logic [ROW_W-1:0] r;
    for (int j = 0; j < WO; j++) r[j*WIDTH +: WIDTH] = e;
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] exp_row(input logic [ROW_W-1:0] d);
    logic [ROW_W-1:0] r;
    r = d;
`ifdef MATMUL_COLLECTOR_RELU_EN
    for (int j = 0; j < WO; j++)
      if ($signed(d[j*WIDTH +: WIDTH]) < 0) r[j*WIDTH +: WIDTH] = '0;
`endif
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_in_cnt = 0; m_err_ov = 0; m_err_last = 0;
  endtask

  task automatic model_step(input bit en, input bit iv, input logic [ROW_W-1:0] d,
                            input bit il, input bit rdy);
    row_t r, h;
    bit pop, acc;
    acc = 0;
    if (m_state == 0) begin
      if (en) m_state = 1;
    end else if (m_state == 1) begin
      if (en) begin
        pop = (mq.size() > 0) && rdy;
        if (iv && m_in_cnt < IO) begin
          if (mq.size() < DEPTH || pop) begin
            if (il != (m_in_cnt == IO - 1)) m_err_last = 1;
            r.last = (m_in_cnt == IO - 1);
            r.data = exp_row(d);
            m_in_cnt++;
            acc = 1;
          end else begin
            m_err_ov = 1;
          end
        end
        if (pop) begin
          h = mq.pop_front();
          if (h.last) m_state = 2;
        end
        if (acc) mq.push_back(r);
      end
    end else begin
      if (!en) begin m_state = 0; m_in_cnt = 0; end
    end
  endtask

  task automatic compare_outputs();
    bit ev;
    ev = (m_state == 1) && (mq.size() > 0);
    check_val("out_valid", ROW_W'(bus.out_valid), ROW_W'(ev));
    check_val("out_last", ROW_W'(bus.out_last), ROW_W'(ev && mq[0].last));
    check_val("out_done", ROW_W'(bus.out_done), ROW_W'(m_state == 2));
    check_val("err_overflow", ROW_W'(bus.err_overflow), ROW_W'(m_err_ov));
    check_val("err_last", ROW_W'(bus.err_last), ROW_W'(m_err_last));
    if (ev) check_val("out_data", bus.out_data, mq[0].data);
  endtask

  // Drive one cycle's inputs (called just after a falling edge).
  task automatic cycle(input bit en, input bit iv, input logic [ROW_W-1:0] d,
                       input bit il, input bit rdy);
    bus.en_collector = en;
    bus.in_row_valid = iv;
    bus.in_row_data  = d;
    bus.in_row_last  = il;
    bus.out_ready    = rdy;
    if (bus.out_valid && rdy && en) begin
      if (bus.out_last) last_at = n_out;
      n_out++;
    end
    model_step(en, iv, d, il, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_valid"}, ROW_W'(bus.out_valid), '0);
    check_val({tag, "_data"}, bus.out_data, '0);
    check_val({tag, "_last"}, ROW_W'(bus.out_last), '0);
    check_val({tag, "_done"}, ROW_W'(bus.out_done), '0);
    check_val({tag, "_errov"}, ROW_W'(bus.err_overflow), '0);
    check_val({tag, "_errlast"}, ROW_W'(bus.err_last), '0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    bus.en_collector = 1'b0; bus.in_row_valid = 1'b0; bus.in_row_data = '0;
    bus.in_row_last = 1'b0;  bus.out_ready = 1'b0;
    #1;
    check_zero_outputs(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_out = 0; last_at = -1;
  endtask

  task automatic send_rows(input int n, input int first, input bit rdy);
    for (int i = 0; i < n; i++)
      cycle(1'b1, 1'b1, fill_row(WIDTH'(i + first)), (m_in_cnt == IO - 1), rdy);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [ROW_W-1:0] rnd;
    logic [WIDTH-1:0] neg_elem;
    bit               en, il;

    // Basic matmul: 12 rows of 1.0, consumer always ready.
    do_reset("rst0");
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < IO; i++)
      cycle(1'b1, 1'b1, fill_row(16'h0100), (i == IO - 1), 1'b1);
    drain(3);
    check_val("basic_rows_out", ROW_W'(n_out), ROW_W'(IO));
    check_val("basic_last_idx", ROW_W'(last_at), ROW_W'(IO - 1));
    check_val("basic_done", ROW_W'(bus.out_done), ROW_W'(1));
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Overflow: 4 rows stall, 5th dropped, then exactly rows 0-3 drain.
    do_reset("rst1");
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    send_rows(5, 1, 1'b0);
    check_val("ovf_flag", ROW_W'(bus.err_overflow), ROW_W'(1));
    n_out = 0;
    drain(6);
    check_val("ovf_rows_out", ROW_W'(n_out), ROW_W'(DEPTH));

    // Full buffer with simultaneous push and pop keeps occupancy at 4.
    do_reset("rst2");
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    send_rows(4, 1, 1'b0);
    cycle(1'b1, 1'b1, fill_row(16'h0055), 1'b0, 1'b1);
    check_val("full_pp_noovf", ROW_W'(bus.err_overflow), ROW_W'(0));
    n_out = 0;
    drain(6);
    check_val("full_pp_rows", ROW_W'(n_out), ROW_W'(DEPTH));

    // Early last flag on row 5 is sticky until reset.
    do_reset("rst3");
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 1'b1, fill_row(WIDTH'(i)), (i == 5), 1'b1);
    check_val("errlast_set", ROW_W'(bus.err_last), ROW_W'(1));
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    drain(4);
    check_val("errlast_sticky", ROW_W'(bus.err_last), ROW_W'(1));

    // Reset mid-operation, then a full clean matmul.
    do_reset("rst4");
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    send_rows(6, 1, 1'b0);
    do_reset("rst_mid");
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    send_rows(IO, 16, 1'b1);
    drain(3);
    check_val("midrst_last_idx", ROW_W'(last_at), ROW_W'(IO - 1));

    // Negative element -1.0 through the datapath.
    do_reset("rst5");
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, fill_row(16'hFF00), 1'b0, 1'b0);
    neg_elem = bus.out_data[WIDTH-1:0];
`ifdef MATMUL_COLLECTOR_RELU_EN
    check_val("relu_elem", ROW_W'(neg_elem), ROW_W'(16'h0000));
`else
    check_val("relu_elem", ROW_W'(neg_elem), ROW_W'(16'hFF00));
`endif

    // Random traffic: enable gaps, stalls, occasional bad last flags.
    for (int run = 0; run < 8; run++) begin
      do_reset("rst_rnd");
      for (int c = 0; c < 250; c++) begin
        rnd = {$urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) rnd[WIDTH-1] = 1'b1;
        en = ($urandom_range(0, 9) != 0);
        il = (m_in_cnt == IO - 1) ^ ($urandom_range(0, 39) == 0);
        cycle(en, 1'($urandom_range(0, 1)), rnd, il, ($urandom_range(0, 2) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
